// File: rtl/alu_issue_ctrl.sv
// Command FIFO + registered response slot wrapped around the external 8-bit combinational ALU.
// Optional macro ALU_DIVZERO_CHK_EN adds rsp_err and forces 8'hFF on divide-by-zero captures.
module alu_issue_ctrl #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_a,
    input  logic [7:0]    cmd_b,
    input  logic [3:0]    cmd_sel,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_sel,
    input  logic [7:0]    alu_out,
    input  logic          alu_carry,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic          rsp_carry,
    output logic [3:0]    rsp_sel,
    output logic [AW:0]   count
`ifdef ALU_DIVZERO_CHK_EN
    ,
    output logic          rsp_err
`endif
);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // The slot is free either when empty or when its current result leaves this cycle.
    assign pop       = !empty && (!rsp_valid || rsp_ready);

    assign head    = mem[rd_ptr];
    assign alu_a   = empty ? 8'h00 : head.a;
    assign alu_b   = empty ? 8'h00 : head.b;
    assign alu_sel = empty ? 4'h0  : head.sel;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

`ifdef ALU_DIVZERO_CHK_EN
    logic div_zero;
    assign div_zero = (head.sel == 4'b0011) && (head.b == 8'h00);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_carry <= 1'b0;
            rsp_sel   <= 4'h0;
`ifdef ALU_DIVZERO_CHK_EN
            rsp_err   <= 1'b0;
`endif
        end else if (pop) begin
            rsp_valid <= 1'b1;
            rsp_carry <= alu_carry;
            rsp_sel   <= head.sel;
`ifdef ALU_DIVZERO_CHK_EN
            rsp_data  <= div_zero ? 8'hFF : alu_out;
            rsp_err   <= div_zero;
`else
            rsp_data  <= alu_out;
`endif
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table for single ops plus backpressure and reset sequences.
module tb_alu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_sel;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_carry;
    logic [3:0]  rsp_sel;
    logic [AW:0] count;
`ifdef ALU_DIVZERO_CHK_EN
    logic        rsp_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_sel(rsp_sel),
        .count(count)
`ifdef ALU_DIVZERO_CHK_EN
        , .rsp_err(rsp_err)
`endif
    );

    // Stand-in for the combinational ALU; carry is always the carry of A+B.
    logic [8:0] sum9;
    always_comb begin
        sum9      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = sum9[8];
        alu_out   = 8'h00;
        case (alu_sel)
            4'b0000: alu_out = sum9[7:0];
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a * alu_b;
            4'b0011: alu_out = (alu_b == 8'h00) ? 8'hAA : alu_a / alu_b;
            4'b0100: alu_out = alu_a << 1;
            4'b0101: alu_out = alu_a >> 1;
            4'b0110: alu_out = alu_a & alu_b;
            4'b0111: alu_out = alu_a | alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    vec_t vt [7];
    logic [7:0] bp_a   [6];
    logic [7:0] bp_b   [6];
    logic [7:0] bp_exp [6];
    int got, cyc;

    initial begin
        vt[0] = '{8'h0F, 8'h01, 4'b0000, 8'h10, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 4'b0000, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h05, 8'h07, 4'b0001, 8'hFE, 1'b0, 1'b0};
        vt[3] = '{8'hF0, 8'h3C, 4'b0110, 8'h30, 1'b1, 1'b0};
        vt[4] = '{8'h80, 8'h01, 4'b0100, 8'h00, 1'b0, 1'b0};
`ifdef ALU_DIVZERO_CHK_EN
        vt[5] = '{8'h10, 8'h00, 4'b0011, 8'hFF, 1'b0, 1'b1};
`else
        vt[5] = '{8'h10, 8'h00, 4'b0011, 8'hAA, 1'b0, 1'b0};
`endif
        vt[6] = '{8'h10, 8'h02, 4'b0011, 8'h08, 1'b0, 1'b0};
        bp_a   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        bp_b   = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        bp_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_a = 8'h00; cmd_b = 8'h00; cmd_sel = 4'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_count",     32'(count),     0);
        chk("rst_alu_sel",   32'(alu_sel),   0);
        chk("rst_alu_a",     32'(alu_a),     0);
        chk("rst_rsp_data",  32'(rsp_data),  0);

        // Single ops: one edge after push nothing yet, second edge gives the result.
        for (int i = 0; i < 7; i++) begin
            push1(vt[i].a, vt[i].b, vt[i].sel);
            chk($sformatf("v%0d_early_valid", i), 32'(rsp_valid), 0);
            chk($sformatf("v%0d_count1", i),      32'(count),     1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("v%0d_data", i),  32'(rsp_data),  32'(vt[i].exp_data));
            chk($sformatf("v%0d_carry", i), 32'(rsp_carry), 32'(vt[i].exp_carry));
            chk($sformatf("v%0d_sel", i),   32'(rsp_sel),   32'(vt[i].sel));
`ifdef ALU_DIVZERO_CHK_EN
            chk($sformatf("v%0d_err", i),   32'(rsp_err),   32'(vt[i].exp_err));
`endif
        end
        @(posedge clk); #1;
        chk("drain_valid", 32'(rsp_valid), 0);

        // Backpressure: 1 captured + 4 queued, 6th stalls until the slot drains.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push1(bp_a[i], bp_b[i], 4'b0000);
        chk("bp_count_full", 32'(count),     4);
        chk("bp_not_ready",  32'(cmd_ready), 0);
        chk("bp_held_data",  32'(rsp_data),  32'(bp_exp[0]));
        cmd_a = bp_a[5]; cmd_b = bp_b[5]; cmd_sel = 4'b0000; cmd_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_stall_count", 32'(count),     4);
        chk("bp_stall_ready", 32'(cmd_ready), 0);
        chk("bp_stall_data",  32'(rsp_data),  32'(bp_exp[0]));
        rsp_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 6 && cyc < 20) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("bp_res%0d", got), 32'(rsp_data), 32'(bp_exp[got]));
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk("bp_pop_count", 32'(count),     3);
                chk("bp_pop_ready", 32'(cmd_ready), 1);
            end
            if (cyc == 2) begin
                cmd_valid = 1'b0;
                chk("bp_pushpop_count", 32'(count), 3);
            end
        end
        chk("bp_got_all",   got,  6);
        chk("bp_rate",      cyc,  6);
        chk("bp_end_count", 32'(count), 0);

        // Reset with 3 queued and 1 held response discards everything.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push1(bp_a[i], bp_b[i], 4'b0000);
        chk("mr_pre_count", 32'(count), 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mr_rsp_valid", 32'(rsp_valid), 0);
        chk("mr_count",     32'(count),     0);
        chk("mr_cmd_ready", 32'(cmd_ready), 1);
        rsp_ready = 1'b1;
        push1(8'h20, 8'h03, 4'b0000);
        @(posedge clk); #1;
        chk("mr_new_valid", 32'(rsp_valid), 1);
        chk("mr_new_data",  32'(rsp_data),  8'h23);
        @(posedge clk); #1;
        chk("mr_no_stale",  32'(rsp_valid), 0);
        chk("mr_end_count", 32'(count),     0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
